spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) for the Avalon-MM SoC fabric. It is the far end of the team's SPI master IP.
- Oversamples external sclk/cs_n/mosi on the system clock.
- Deserializes received words into an RX FIFO.
- Serializes a single-word TX holding register onto miso.
- Software accesses it through a 4-word register aperture.

Parameters:
RX_DEPTH, 16, RX FIFO depth in words (power of 2, >=2)
SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and mosi (>=2)

Ports:
clk  in  1  system clock; must be >= 8x sclk frequency
reset  in  1  reset, synchronous, active-high
address  in  2  register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 LEVEL
byteenable  in  4  ignored; all writes are full-word
chipselect  in  1  Avalon select
read  in  1  Avalon read
write  in  1  Avalon write
writedata  in  32  write data
readdata  out  32  combinational read data; 0 when not (read && chipselect)
sclk  in  1  SPI clock from master, asynchronous
cs_n  in  1  SPI select, active-low, asynchronous
mosi  in  1  SPI data in, asynchronous
miso  out  1  SPI data out; 0 while cs_n high or engine disabled

Behaviour:
Reset values:
- miso=0, CONTROL=0, all sticky flags 0, RX FIFO empty, TX holding register empty, engine IDLE.

Synchronization:
- sclk, cs_n and mosi each pass through SYNC_STAGES flops.
- Edges are detected against the previous synced value: one-clk rise/fall pulses.
- mosi is captured from the synced value on the same clk as the sclk rise pulse.

Registers:
- CONTROL:
  - [4:0] len-1, giving a word length of 1..32.
  - [15] enable. When enable=0, the engine is held IDLE and miso=0. FIFO and holding register contents are kept.
- STATUS (read): {24'b0, abrt[7], busy[6], txov[5], txur[4], txe[3], rxfo[2], rxff[1], rxfe[0]}.
  - abrt, txov, txur and rxfo are sticky and write-1-to-clear.
  - A set event coincident with a clear wins.
- DATA read returns the RX FIFO head (0 if empty). The pop occurs once, on the first clk of a read && chipselect && address==0 access (rising-edge qualified).
- DATA write loads the TX holding register and clears txe. If txe=0, the write is ignored and txov is set.
- LEVEL read returns the RX FIFO occupancy, 0..RX_DEPTH.

Engine states:
- IDLE: cs_n synced high. On cs_n fall:
  - Latch len from CONTROL.
  - bitcnt=0.
  - Load tx_sh from the holding register and set txe=1. If txe was already 1, load 0 and set txur.
  - Go to ACTIVE. busy=1 in ACTIVE.
- ACTIVE:
  - miso = tx_sh[len-1].
  - sclk rise: rx_sh <= {rx_sh[30:0], mosi}; bitcnt++.
  - If bitcnt reaches len: push rx_sh[len-1:0], zero-extended, into the RX FIFO; bitcnt=0; reload tx_sh as on cs_n fall.
  - sclk fall: shift tx_sh left by 1, but only if bitcnt != 0. This keeps a freshly loaded MSB in place.
  - cs_n rise: go to IDLE. If bitcnt != 0, discard the partial word and set abrt.

Boundary conditions:
- Push when the RX FIFO is full: word dropped, rxfo set, FIFO unchanged.
- Push and pop on the same clk: both occur; level unchanged. With the FIFO full, the push is accepted.
- Pop when empty: no change.
- Pointers wrap modulo RX_DEPTH.
- len changes mid-frame take effect at the next cs_n fall.
- Reset mid-frame: immediate return to reset values. The frame in progress is lost, and abrt is not set.

Optional Feature:
Macro: SPI_SLAVE_IRQ_EN
- Defined:
  - Adds output port irq (1 bit, registered, reset 0).
  - Adds CONTROL[16] rx_ie and CONTROL[17] err_ie.
  - irq = (rx_ie && !rxfe) || (err_ie && (rxfo || txur || txov || abrt)).
- Undefined: no irq port; CONTROL[17:16] read back 0 and are not stored.

Test Plan:
1. CONTROL=0x8007, write DATA=0xA5. Master sends 0x3C, 8 bits → DATA reads 0x3C; master receives 0xA5; LEVEL 1→0 after the read; txe=1.
2. len=8, no DATA write, master sends 0x55 → miso returns 0x00; txur=1. Write STATUS 0x10 → txur=0.
3. Fill 16 words (0..15), then a 17th word 0xFF → LEVEL=16, rxff=1, rxfo=1. Reads return 0..15 in order, then rxfe=1.
4. len=32, two back-to-back words in one cs_n frame: 0xDEADBEEF, 0x12345678. Holding register reloaded between them with 0xCAFEF00D → both received intact; miso carries 0xCAFEF00D for the second word.
5. len=8, cs_n deasserted after 5 bits → LEVEL unchanged, abrt=1. The next full frame, 0x81, is received correctly.
6. With SPI_SLAVE_IRQ_EN and rx_ie=1: irq=0 while empty, irq=1 after a word arrives, irq=0 after the read.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled sclk/cs_n/mosi, RX FIFO, single-word TX holding register, 4-word register aperture.
// Defining SPI_SLAVE_IRQ_EN adds the irq output and the CONTROL[17:16] interrupt enables.
module spi_slave #(
    parameter int unsigned RX_DEPTH    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic [3:0]  byteenable,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
`ifdef SPI_SLAVE_IRQ_EN
    output logic        irq,
`endif
    output logic        miso
);
    localparam int unsigned AW = $clog2(RX_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_e      state_q;
    logic [4:0]  bitcnt_q, lenm1_q;
    logic [31:0] tx_sh_q, rx_sh_q, rx_next, push_data, tx_load_val;
    logic        start, word_done, abort_evt, tx_load;

    logic [4:0]  ctrl_len_q;
    logic        ctrl_en_q;
`ifdef SPI_SLAVE_IRQ_EN
    logic        rx_ie_q, err_ie_q, irq_q;
`endif
    logic [31:0] hold_q, hold_d;
    logic        txe_q, txe_d, txur_q, txur_d, txov_q, txov_d;
    logic        abrt_q, abrt_d, rxfo_q, rxfo_d;
    logic        data_rd_q;

    logic [31:0] mem_q [RX_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    logic          fifo_full, fifo_empty, pop, push_ok;
    logic          bus_rd, data_rd, data_wr, stat_wr, ctrl_wr;
    logic          unused_byteenable;

    assign unused_byteenable = ^byteenable;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign bus_rd     = chipselect && read;
    assign data_rd    = bus_rd && (address == 2'd0);
    assign data_wr    = chipselect && write && (address == 2'd0);
    assign stat_wr    = chipselect && write && (address == 2'd1);
    assign ctrl_wr    = chipselect && write && (address == 2'd2);
    assign fifo_full  = (count_q == (AW+1)'(RX_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = data_rd && !data_rd_q && !fifo_empty;

    always_comb begin
        rx_next     = {rx_sh_q[30:0], mosi_s};
        push_data   = rx_next & ({32{1'b1}} >> (5'd31 - lenm1_q));
        tx_load_val = txe_q ? '0 : hold_q;
        start       = (state_q == IDLE) && ctrl_en_q && cs_fall;
        word_done   = (state_q == ACTIVE) && ctrl_en_q && !cs_rise && sclk_rise && (bitcnt_q == lenm1_q);
        abort_evt   = (state_q == ACTIVE) && ctrl_en_q && cs_rise && (bitcnt_q != '0);
        tx_load     = start || word_done;
        push_ok     = word_done && (!fifo_full || pop);
    end

    // A word boundary leaves bitcnt at 0, so the following sclk fall keeps the reloaded MSB on miso.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            lenm1_q  <= '0;
            tx_sh_q  <= '0;
            rx_sh_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= ACTIVE;
                        lenm1_q  <= ctrl_len_q;
                        bitcnt_q <= '0;
                        tx_sh_q  <= tx_load_val;
                    end
                end
                ACTIVE: begin
                    if (!ctrl_en_q || cs_rise) begin
                        state_q  <= IDLE;
                        bitcnt_q <= '0;
                    end else if (sclk_rise) begin
                        rx_sh_q <= rx_next;
                        if (word_done) begin
                            bitcnt_q <= '0;
                            tx_sh_q  <= tx_load_val;
                        end else begin
                            bitcnt_q <= bitcnt_q + 5'd1;
                        end
                    end else if (sclk_fall && bitcnt_q != '0) begin
                        tx_sh_q <= {tx_sh_q[30:0], 1'b0};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso = (state_q == ACTIVE) && ctrl_en_q && tx_sh_q[lenm1_q];

    // Clears are applied before sets so a coincident set event wins.
    always_comb begin
        hold_d = hold_q;
        txe_d  = txe_q;
        txur_d = txur_q;
        txov_d = txov_q;
        abrt_d = abrt_q;
        rxfo_d = rxfo_q;
        if (stat_wr) begin
            abrt_d = abrt_q & ~writedata[7];
            txov_d = txov_q & ~writedata[5];
            txur_d = txur_q & ~writedata[4];
            rxfo_d = rxfo_q & ~writedata[2];
        end
        if (tx_load) begin
            txe_d = 1'b1;
            if (txe_q) txur_d = 1'b1;
        end
        if (data_wr) begin
            if (txe_q) begin
                hold_d = writedata;
                txe_d  = 1'b0;
            end else begin
                txov_d = 1'b1;
            end
        end
        if (abort_evt) abrt_d = 1'b1;
        if (word_done && fifo_full && !pop) rxfo_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_len_q <= '0;
            ctrl_en_q  <= 1'b0;
`ifdef SPI_SLAVE_IRQ_EN
            rx_ie_q    <= 1'b0;
            err_ie_q   <= 1'b0;
`endif
            hold_q     <= '0;
            txe_q      <= 1'b1;
            txur_q     <= 1'b0;
            txov_q     <= 1'b0;
            abrt_q     <= 1'b0;
            rxfo_q     <= 1'b0;
            data_rd_q  <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
        end else begin
            if (ctrl_wr) begin
                ctrl_len_q <= writedata[4:0];
                ctrl_en_q  <= writedata[15];
`ifdef SPI_SLAVE_IRQ_EN
                rx_ie_q    <= writedata[16];
                err_ie_q   <= writedata[17];
`endif
            end
            hold_q    <= hold_d;
            txe_q     <= txe_d;
            txur_q    <= txur_d;
            txov_q    <= txov_d;
            abrt_q    <= abrt_d;
            rxfo_q    <= rxfo_d;
            data_rd_q <= data_rd;
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= push_data;
    end

`ifdef SPI_SLAVE_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= (rx_ie_q && !fifo_empty) || (err_ie_q && (rxfo_q || txur_q || txov_q || abrt_q));
    end
    assign irq = irq_q;
`endif

    always_comb begin
        readdata = '0;
        if (bus_rd) begin
            case (address)
                2'd0: readdata = fifo_empty ? '0 : mem_q[rd_q];
                2'd1: readdata = {24'b0, abrt_q, (state_q == ACTIVE), txov_q, txur_q, txe_q, rxfo_q, fifo_full, fifo_empty};
`ifdef SPI_SLAVE_IRQ_EN
                2'd2: readdata = {14'b0, err_ie_q, rx_ie_q, ctrl_en_q, 10'b0, ctrl_len_q};
`else
                2'd2: readdata = {16'b0, ctrl_en_q, 10'b0, ctrl_len_q};
`endif
                default: readdata = 32'(count_q);
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a transaction-level model of the register file, RX queue and TX slot,
// checked every clock by one compare process, plus directed frames with literal expectations and random frames.
module tb_spi_slave;
    localparam int unsigned DEPTH = 16;
    localparam int HALF = 6;
`ifdef SPI_SLAVE_IRQ_EN
    localparam logic [31:0] CTRL_MASK = 32'h0003_801F;
`else
    localparam logic [31:0] CTRL_MASK = 32'h0000_801F;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic [3:0]  byteenable = '0;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        sclk_in = 1'b0, cs_n_in = 1'b1, mosi_in = 1'b0;
    logic        miso;
`ifdef SPI_SLAVE_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    spi_slave #(.RX_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .readdata(readdata), .sclk(sclk_in), .cs_n(cs_n_in), .mosi(mosi_in),
`ifdef SPI_SLAVE_IRQ_EN
        .irq(irq),
`endif
        .miso(miso)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural model state
    logic [31:0] rxq [$];
    logic        m_txe = 1'b1, m_txur = 1'b0, m_txov = 1'b0, m_abrt = 1'b0, m_rxfo = 1'b0;
    logic [31:0] m_hold = '0, m_ctrl = '0;
    logic        spi_idle = 1'b0, chk_miso = 1'b0, exp_miso = 1'b0;
    logic [31:0] exp_rd;
    logic [31:0] tx_words [0:31];
    logic [31:0] got_words [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] len_mask(input int len);
        logic [31:0] m;
        m = '1;
        return m >> (32 - len);
    endfunction

    function automatic logic [31:0] m_status();
        return {24'b0, m_abrt, 1'b0, m_txov, m_txur, m_txe, m_rxfo,
                rxq.size() == DEPTH, rxq.size() == 0};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (chipselect && read) begin
                case (address)
                    2'd0: exp_rd = (rxq.size() != 0) ? rxq[0] : 32'h0;
                    2'd1: exp_rd = m_status();
                    2'd2: exp_rd = m_ctrl & CTRL_MASK;
                    default: exp_rd = 32'(rxq.size());
                endcase
                chk("readdata", readdata, exp_rd);
                if (address == 2'd0 && rxq.size() != 0) void'(rxq.pop_front());
            end else begin
                chk("readdata_idle", readdata, 32'h0);
            end
            if (chk_miso)      chk("miso_bit", {31'b0, miso}, {31'b0, exp_miso});
            else if (spi_idle) chk("miso_idle", {31'b0, miso}, 32'h0);
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        case (a)
            2'd0: if (m_txe) begin m_hold = d; m_txe = 1'b0; end else m_txov = 1'b1;
            2'd1: begin
                if (d[7]) m_abrt = 1'b0;
                if (d[5]) m_txov = 1'b0;
                if (d[4]) m_txur = 1'b0;
                if (d[2]) m_rxfo = 1'b0;
            end
            2'd2: m_ctrl = d;
            default: ;
        endcase
        @(posedge clk); #1;
        address = a; writedata = d; byteenable = 4'($urandom()); write = 1'b1; chipselect = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; chipselect = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        address = a; read = 1'b1; chipselect = 1'b1;
        @(negedge clk);
        d = readdata;
        @(posedge clk); #1;
        read = 1'b0; chipselect = 1'b0;
    endtask

    task automatic load_model(output logic [31:0] v);
        if (m_txe) begin v = '0; m_txur = 1'b1; end
        else v = m_hold;
        m_txe = 1'b1;
    endtask

    // Sends nwords full words from tx_words then 'extra' bits of a partial word, within one cs_n frame.
    task automatic spi_frame(input int nwords, input int extra, input bit mid_wr, input logic [31:0] mid_val);
        int len, nb;
        logic [31:0] txv, w, got;
        len = int'(m_ctrl[4:0]) + 1;
        got_words.delete();
        spi_idle = 1'b0;
        @(posedge clk); #1;
        cs_n_in = 1'b0;
        load_model(txv);
        for (int k = 0; k <= nwords; k++) begin
            nb = (k < nwords) ? len : extra;
            w  = (k < nwords) ? tx_words[k] : $urandom();
            got = '0;
            for (int b = 0; b < nb; b++) begin
                mosi_in = w[len-1-b];
                repeat (HALF) @(posedge clk);
                #1;
                exp_miso = txv[len-1-b];
                chk_miso = 1'b1;
                @(negedge clk);
                got = {got[30:0], miso};
                #1 chk_miso = 1'b0;
                @(posedge clk); #1;
                sclk_in = 1'b1;
                if (mid_wr && k == 0 && b == 2) begin
                    bus_write(2'd0, mid_val);
                    repeat (HALF - 2) @(posedge clk);
                end else begin
                    repeat (HALF) @(posedge clk);
                end
                #1 sclk_in = 1'b0;
            end
            if (k < nwords) begin
                if (rxq.size() < DEPTH) rxq.push_back(w & len_mask(len));
                else m_rxfo = 1'b1;
                got_words.push_back(got);
                load_model(txv);
            end
        end
        if (extra > 0) m_abrt = 1'b1;
        repeat (HALF) @(posedge clk);
        #1 cs_n_in = 1'b1;
        repeat (HALF) @(posedge clk);
        spi_idle = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int len, nw, extra, nr;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        spi_idle = 1'b1;

        // Reset state
        bus_read(2'd1, d); chk("reset_status", d, 32'h0000_0009);
        bus_read(2'd0, d); chk("reset_data", d, 32'h0);
        bus_read(2'd2, d); chk("reset_ctrl", d, 32'h0);
        bus_read(2'd3, d); chk("reset_level", d, 32'h0);

        // 1: basic 8-bit exchange
        bus_write(2'd2, 32'h0000_8007);
        bus_write(2'd0, 32'h0000_00A5);
        tx_words[0] = 32'h3C;
        spi_frame(1, 0, 1'b0, '0);
        chk("t1_master_rx", got_words[0], 32'hA5);
        bus_read(2'd3, d); chk("t1_level_before", d, 32'd1);
        bus_read(2'd0, d); chk("t1_data", d, 32'h3C);
        bus_read(2'd3, d); chk("t1_level_after", d, 32'd0);
        bus_read(2'd1, d); chk("t1_txe", d & 32'h8, 32'h8);

        // 2: underrun
        bus_write(2'd1, 32'h10);
        tx_words[0] = 32'h55;
        spi_frame(1, 0, 1'b0, '0);
        chk("t2_master_rx", got_words[0], 32'h0);
        bus_read(2'd1, d); chk("t2_txur_set", d & 32'h10, 32'h10);
        bus_write(2'd1, 32'h10);
        bus_read(2'd1, d); chk("t2_txur_clr", d & 32'h10, 32'h0);
        bus_read(2'd0, d); chk("t2_data", d, 32'h55);

        // 3: overflow
        for (int i = 0; i < 16; i++) tx_words[i] = 32'(i);
        tx_words[16] = 32'hFF;
        spi_frame(17, 0, 1'b0, '0);
        bus_read(2'd3, d); chk("t3_level", d, 32'd16);
        bus_read(2'd1, d); chk("t3_flags", d & 32'h7, 32'h6);
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, d); chk("t3_order", d, 32'(i));
        end
        bus_read(2'd1, d); chk("t3_empty", d & 32'h3, 32'h1);
        bus_write(2'd1, 32'h04);

        // 4: 32-bit back-to-back words with a mid-frame holding reload
        bus_write(2'd2, 32'h0000_801F);
        bus_write(2'd0, 32'h1122_3344);
        tx_words[0] = 32'hDEAD_BEEF;
        tx_words[1] = 32'h1234_5678;
        spi_frame(2, 0, 1'b1, 32'hCAFE_F00D);
        chk("t4_master_w0", got_words[0], 32'h1122_3344);
        chk("t4_master_w1", got_words[1], 32'hCAFE_F00D);
        bus_read(2'd0, d); chk("t4_data0", d, 32'hDEAD_BEEF);
        bus_read(2'd0, d); chk("t4_data1", d, 32'h1234_5678);

        // 5: abort after 5 bits, then a clean frame
        bus_write(2'd2, 32'h0000_8007);
        spi_frame(0, 5, 1'b0, '0);
        bus_read(2'd3, d); chk("t5_level", d, 32'd0);
        bus_read(2'd1, d); chk("t5_abrt", d & 32'h80, 32'h80);
        bus_write(2'd1, 32'h80);
        tx_words[0] = 32'h81;
        spi_frame(1, 0, 1'b0, '0);
        bus_read(2'd0, d); chk("t5_data", d, 32'h81);

`ifdef SPI_SLAVE_IRQ_EN
        // 6: receive interrupt
        bus_write(2'd2, 32'h0001_8007);
        repeat (3) @(posedge clk);
        #1 chk("t6_irq_empty", {31'b0, irq}, 32'h0);
        tx_words[0] = 32'h42;
        spi_frame(1, 0, 1'b0, '0);
        chk("t6_irq_rx", {31'b0, irq}, 32'h1);
        bus_read(2'd0, d);
        repeat (3) @(posedge clk);
        #1 chk("t6_irq_read", {31'b0, irq}, 32'h0);
`endif

        // Random frames against the model
        for (int it = 0; it < 25; it++) begin
            len = $urandom_range(1, 32);
            d = $urandom();
            d[15] = 1'b1;
            d[4:0] = 5'(len - 1);
            bus_write(2'd2, d);
            if ($urandom_range(0, 1) == 1) bus_write(2'd0, $urandom());
            if ($urandom_range(0, 3) == 0) bus_write(2'd0, $urandom());
            nw = $urandom_range(1, 2);
            for (int k = 0; k < nw; k++) tx_words[k] = $urandom() & len_mask(len);
            extra = ($urandom_range(0, 4) == 0 && len > 1) ? $urandom_range(1, len - 1) : 0;
            spi_frame(nw, extra, 1'b0, '0);
            nr = $urandom_range(0, 3);
            for (int r = 0; r < nr; r++) bus_read(2'd0, d);
            bus_read(2'd1, d);
            bus_read(2'd3, d);
            bus_read(2'd2, d);
            if ($urandom_range(0, 2) == 0) bus_write(2'd1, $urandom());
        end
        while (rxq.size() > 0) bus_read(2'd0, d);
        bus_read(2'd3, d);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
